// File: rtl/exception_branch_ctrl_pkg.sv
// Shared Kabeta control encodings: branch conditions, PC select codes, vectors and cause sources.
// Also holds the controller FSM state type and the exception vector helper.
package kabeta_defs;

  localparam logic [1:0] BRC_NONE  = 2'd0;
  localparam logic [1:0] BRC_EQ    = 2'd1;
  localparam logic [1:0] BRC_NE    = 2'd2;
  localparam logic [1:0] BRC_AL    = 2'd3;

  localparam logic [1:0] PCS_PCNX  = 2'd0;
  localparam logic [1:0] PCS_PCLIT = 2'd1;
  localparam logic [1:0] PCS_REGA  = 2'd2;
  localparam logic [1:0] PCS_EXCA  = 2'd3;

  localparam logic [31:0] EV_RST      = 32'hFFFF_0000;
  localparam logic [31:0] EV_INV_IA   = 32'hFFFF_0040;
  localparam logic [31:0] EV_EXC_BASE = 32'hFFFF_0100;
  localparam logic [31:0] EV_INT_BASE = 32'hFFFF_0800;

  localparam logic [1:0] CSRC_EXC = 2'd0;
  localparam logic [1:0] CSRC_IRQ = 2'd1;
  localparam logic [1:0] CSRC_RST = 2'd2;

  localparam logic [7:0] CAUSE_RST = {CSRC_RST, 3'd0, 3'd0};

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOCK = 2'd2
  } ctrl_state_e;

  // Fetch-stage faults share one vector; later stages get a 16-byte slot per {stage, code}.
  function automatic logic [31:0] vector(input logic [2:0] code, input logic [2:0] stage);
    if (stage == 3'd0) return EV_INV_IA;
    return EV_EXC_BASE + {22'd0, stage, code, 4'd0};
  endfunction

endpackage

// File: rtl/exception_branch_ctrl_irq_pending_latch.sv
// Rising-edge interrupt capture with sticky pending bits and masked fixed-priority selection.
// Line 0 wins; an edge arriving in the same cycle as its ack re-arms the pending bit.
module irq_pending_latch #(
  parameter int NUM_IRQ = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_IRQ-1:0] line_i,
  input  logic [NUM_IRQ-1:0] mask_i,
  input  logic [NUM_IRQ-1:0] ack_i,
  output logic               valid_o,
  output logic [NUM_IRQ-1:0] sel_o,
  output logic [2:0]         idx_o
);

  logic [NUM_IRQ-1:0] line_q;
  logic [NUM_IRQ-1:0] pend_q;
  logic [NUM_IRQ-1:0] pend_d;
  logic [NUM_IRQ-1:0] cand;

  assign pend_d = (pend_q & ~ack_i) | (line_i & ~line_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      line_q <= '0;
      pend_q <= '0;
    end else begin
      line_q <= line_i;
      pend_q <= pend_d;
    end
  end

  always_comb begin
    cand  = pend_q & mask_i;
    sel_o = '0;
    idx_o = 3'd0;
    for (int j = NUM_IRQ - 1; j >= 0; j--) begin
      if (cand[j]) begin
        sel_o    = '0;
        sel_o[j] = 1'b1;
        idx_o    = 3'(j);
      end
    end
    valid_o = |cand;
  end

endmodule

// File: rtl/exception_branch_ctrl.sv
// Kabeta branch/exception controller: prioritises stage exceptions, interrupts, branches and stalls
// into PC select, flush and ack; captures EPC/cause and holds off interrupts after any redirect.
module exception_branch_ctrl
  import kabeta_defs::*;
#(
  parameter int NUM_STAGES = 4,
  parameter int NUM_IRQ    = 4,
  parameter int XLEN       = 32,
  parameter int LOCK_CYC   = 2
) (
  input  logic                       clk_i,
  input  logic                       sys_reset_i,
  input  logic [NUM_STAGES-1:0]      exc_req_i,
  input  logic [3*NUM_STAGES-1:0]    exc_code_i,
  input  logic [XLEN*NUM_STAGES-1:0] stage_pc_i,
  input  logic                       stall_i,
  input  logic                       supervisor_i,
  input  logic [NUM_IRQ-1:0]         irq_line_i,
  input  logic [NUM_IRQ-1:0]         irq_mask_i,
  input  logic [1:0]                 br_cond_i,
  input  logic [XLEN-1:0]            ra_i,
  output logic [XLEN-1:0]            exc_addr_o,
  output logic [1:0]                 pc_sel_o,
  output logic [NUM_STAGES-1:0]      flush_o,
  output logic [NUM_STAGES-1:0]      exc_ack_o,
  output logic                       replicate_pc_o,
  output logic [NUM_IRQ-1:0]         irq_ack_o,
  output logic [XLEN-1:0]            epc_o,
  output logic [7:0]                 exc_cause_o,
  output ctrl_state_e                state_o
);

  localparam int CW = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;
  localparam int IRQ_STAGE = NUM_STAGES - 2;

  ctrl_state_e         state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [XLEN-1:0]     epc_q, epc_d;
  logic [7:0]          cause_q, cause_d;

  logic                br_taken;
  logic [NUM_STAGES-1:0] exc_gated;
  logic                exc_hit;
  logic [2:0]          exc_idx;
  logic [2:0]          exc_code;
  logic                irq_valid;
  logic [NUM_IRQ-1:0]  irq_sel;
  logic [2:0]          irq_idx;
  logic                irq_take;
  logic                redirect;

  irq_pending_latch #(.NUM_IRQ(NUM_IRQ)) u_irq (
    .clk_i   (clk_i),
    .rst_i   (sys_reset_i),
    .line_i  (irq_line_i),
    .mask_i  (irq_mask_i),
    .ack_i   (irq_ack_o),
    .valid_o (irq_valid),
    .sel_o   (irq_sel),
    .idx_o   (irq_idx)
  );

  assign br_taken = (br_cond_i == BRC_AL)
                  | ((br_cond_i == BRC_EQ) & (ra_i == '0))
                  | ((br_cond_i == BRC_NE) & (ra_i != '0));

  // IF and ID requests are squashed by a taken branch or a stall; oldest remaining stage wins.
  always_comb begin
    exc_gated = exc_req_i;
    if (br_taken || stall_i) exc_gated[1:0] = 2'b00;
    exc_hit = 1'b0;
    exc_idx = 3'd0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (exc_gated[i]) begin
        exc_hit = 1'b1;
        exc_idx = 3'(i);
      end
    end
    exc_code = exc_code_i[3*exc_idx +: 3];
  end

  assign irq_take = (state_q == ST_RUN) & ~supervisor_i & ~stall_i & irq_valid;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    epc_d          = epc_q;
    cause_d        = cause_q;
    pc_sel_o       = PCS_PCNX;
    exc_addr_o     = XLEN'(EV_RST);
    flush_o        = '0;
    exc_ack_o      = '0;
    replicate_pc_o = 1'b0;
    irq_ack_o      = '0;
    redirect       = 1'b0;
    if (sys_reset_i || state_q == ST_RST) begin
      pc_sel_o = PCS_EXCA;
      state_d  = sys_reset_i ? ST_RST : ST_RUN;
      cnt_d    = '0;
    end else begin
      if (exc_hit) begin
        pc_sel_o           = PCS_EXCA;
        exc_addr_o         = XLEN'(vector(exc_code, exc_idx));
        for (int j = 0; j < NUM_STAGES; j++) flush_o[j] = (j <= int'(exc_idx));
        exc_ack_o[exc_idx] = 1'b1;
        epc_d              = stage_pc_i[XLEN*exc_idx +: XLEN];
        cause_d            = {CSRC_EXC, exc_idx, exc_code};
        redirect           = 1'b1;
      end else if (irq_take) begin
        pc_sel_o             = PCS_EXCA;
        exc_addr_o           = XLEN'(EV_INT_BASE + {26'd0, irq_idx, 3'd0});
        for (int j = 0; j <= IRQ_STAGE; j++) flush_o[j] = 1'b1;
        exc_ack_o[IRQ_STAGE] = 1'b1;
        irq_ack_o            = irq_sel;
        epc_d                = stage_pc_i[XLEN*IRQ_STAGE +: XLEN];
        cause_d              = {CSRC_IRQ, irq_idx, 3'd0};
        redirect             = 1'b1;
      end else if (br_taken) begin
        pc_sel_o       = (br_cond_i == BRC_AL) ? PCS_REGA : PCS_PCLIT;
        flush_o[1:0]   = 2'b11;
        replicate_pc_o = 1'b1;
        redirect       = 1'b1;
      end else if (stall_i) begin
        flush_o[2] = 1'b1;
      end
      if (redirect) begin
        state_d = ST_LOCK;
        cnt_d   = CW'(LOCK_CYC - 1);
      end else if (state_q == ST_LOCK) begin
        if (cnt_q == '0) state_d = ST_RUN;
        else             cnt_d   = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (sys_reset_i) begin
      state_q <= ST_RST;
      cnt_q   <= '0;
      epc_q   <= '0;
      cause_q <= CAUSE_RST;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
    end
  end

  assign epc_o       = epc_q;
  assign exc_cause_o = cause_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_exception_branch_ctrl.sv
// Bench for exception_branch_ctrl: directed scenarios then random traffic, each cycle scored
// against a cycle-level behavioural model through an expected-response queue.
module tb_exception_branch_ctrl;
  import kabeta_defs::*;

  localparam int NS = 4;
  localparam int NI = 4;
  localparam int LOCK_CYC = 2;
  localparam int W = 87;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            drv_reset;
  logic [NS-1:0]   drv_req;
  logic [3*NS-1:0] drv_code;
  logic [32*NS-1:0] drv_pc;
  logic            drv_stall, drv_sup;
  logic [NI-1:0]   drv_line, drv_mask;
  logic [1:0]      drv_br;
  logic [31:0]     drv_ra;

  logic [31:0]     exc_addr, epc;
  logic [1:0]      pc_sel;
  logic [NS-1:0]   flush, exc_ack;
  logic            repl;
  logic [NI-1:0]   irq_ack;
  logic [7:0]      cause;
  ctrl_state_e     dbg_state;

  exception_branch_ctrl #(.NUM_STAGES(NS), .NUM_IRQ(NI), .XLEN(32), .LOCK_CYC(LOCK_CYC)) dut (
    .clk_i(clk), .sys_reset_i(drv_reset), .exc_req_i(drv_req), .exc_code_i(drv_code),
    .stage_pc_i(drv_pc), .stall_i(drv_stall), .supervisor_i(drv_sup), .irq_line_i(drv_line),
    .irq_mask_i(drv_mask), .br_cond_i(drv_br), .ra_i(drv_ra), .exc_addr_o(exc_addr),
    .pc_sel_o(pc_sel), .flush_o(flush), .exc_ack_o(exc_ack), .replicate_pc_o(repl),
    .irq_ack_o(irq_ack), .epc_o(epc), .exc_cause_o(cause), .state_o(dbg_state)
  );

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Behavioural model state
  bit          m_rst_cycle = 1'b1;
  int          m_lock = 0;
  logic [NI-1:0] m_pend = '0;
  logic [NI-1:0] m_prev = '0;
  logic [31:0] m_epc = 32'd0;
  logic [7:0]  m_cause = 8'h80;

  task automatic step();
    logic [31:0] e_addr;
    logic [1:0]  e_pcs;
    logic [3:0]  e_fl, e_ack, e_iack;
    logic        e_rep;
    logic [2:0]  code;
    logic [31:0] n_epc;
    logic [7:0]  n_cause;
    int oldest, irq_k;
    bit brt, redirect;
    e_addr = EV_RST; e_pcs = PCS_PCNX; e_fl = 0; e_ack = 0; e_iack = 0; e_rep = 0;
    n_epc = m_epc; n_cause = m_cause; redirect = 0; code = 0;
    brt = (drv_br == BRC_AL) || (drv_br == BRC_EQ && drv_ra == 0) || (drv_br == BRC_NE && drv_ra != 0);
    if (drv_reset || m_rst_cycle) begin
      e_pcs = PCS_EXCA;
    end else begin
      oldest = -1;
      for (int i = 0; i < NS; i++)
        if (drv_req[i] && !(i < 2 && (brt || drv_stall))) oldest = i;
      irq_k = -1;
      for (int k = NI - 1; k >= 0; k--)
        if (m_pend[k] && drv_mask[k]) irq_k = k;
      if (oldest >= 0) begin
        code    = drv_code[3*oldest +: 3];
        e_pcs   = PCS_EXCA;
        e_addr  = (oldest == 0) ? EV_INV_IA : EV_EXC_BASE + 32'((oldest * 8 + code) * 16);
        e_fl    = 4'((1 << (oldest + 1)) - 1);
        e_ack   = 4'(1 << oldest);
        n_epc   = drv_pc[32*oldest +: 32];
        n_cause = {2'd0, 3'(oldest), code};
        redirect = 1;
      end else if (m_lock == 0 && !drv_sup && !drv_stall && irq_k >= 0) begin
        e_pcs   = PCS_EXCA;
        e_addr  = EV_INT_BASE + 32'(8 * irq_k);
        e_fl    = 4'b0111;
        e_ack   = 4'b0100;
        e_iack  = 4'(1 << irq_k);
        n_epc   = drv_pc[64 +: 32];
        n_cause = {2'd1, 3'(irq_k), 3'd0};
        redirect = 1;
      end else if (brt) begin
        e_pcs = (drv_br == BRC_AL) ? PCS_REGA : PCS_PCLIT;
        e_fl  = 4'b0011;
        e_rep = 1;
        redirect = 1;
      end else if (drv_stall) begin
        e_fl = 4'b0100;
      end
    end
    exp_q.push_back({e_addr, e_pcs, e_fl, e_ack, e_rep, e_iack, m_epc, m_cause});
    if (drv_reset) begin
      m_rst_cycle = 1; m_pend = 0; m_prev = 0; m_epc = 0; m_cause = 8'h80; m_lock = 0;
    end else begin
      for (int k = 0; k < NI; k++)
        m_pend[k] = (m_pend[k] && !e_iack[k]) || (drv_line[k] && !m_prev[k]);
      m_prev = drv_line;
      if (m_rst_cycle) m_lock = 0;
      else if (redirect) m_lock = LOCK_CYC;
      else if (m_lock > 0) m_lock = m_lock - 1;
      m_rst_cycle = 0;
      m_epc = n_epc;
      m_cause = n_cause;
    end
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic idle_inputs();
    drv_req = 0; drv_stall = 0; drv_br = BRC_NONE; drv_ra = 0; drv_line = 0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Monitor: compares the DUT against the oldest expectation at mid-cycle
  always @(negedge clk) begin
    logic [W-1:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {exc_addr, pc_sel, flush, exc_ack, repl, irq_ack, epc, cause};
      if (e[54:53] != PCS_EXCA) begin
        e[86:55] = 32'd0;
        a[86:55] = 32'd0;
      end
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL outputs t=%0t got addr=%h pcs=%0d fl=%b ack=%b rep=%b iack=%b epc=%h cause=%h exp addr=%h pcs=%0d fl=%b ack=%b rep=%b iack=%b epc=%h cause=%h",
                 $time, a[86:55], a[54:53], a[52:49], a[48:45], a[44], a[43:40], a[39:8], a[7:0],
                 e[86:55], e[54:53], e[52:49], e[48:45], e[44], e[43:40], e[39:8], e[7:0]);
      end
    end
  end

  initial begin
    drv_reset = 1; drv_code = 0; drv_pc = 0; drv_sup = 0; drv_mask = 4'hF;
    idle_inputs();
    for (int s = 0; s < NS; s++) drv_pc[32*s +: 32] = 32'h1000 + 32'(s * 4);
    @(posedge clk);
    #2;
    cycles(3);
    drv_reset = 0;
    cycles(3);
    // Two stages fault together; the older one wins
    drv_req = 4'b1010; drv_code = 12'b101_000_011_000; drv_pc[96 +: 32] = 32'h100;
    step();
    idle_inputs();
    cycles(3);
    // Interrupt held off by supervisor mode
    drv_sup = 1; drv_line = 4'b0100; step(); drv_line = 0;
    cycles(4);
    drv_sup = 0;
    cycles(4);
    // Masked interrupt stays pending until enabled
    drv_mask = 4'b1101; drv_line = 4'b0010; step(); drv_line = 0;
    cycles(2);
    drv_mask = 4'hF;
    cycles(4);
    // BNE not taken, then taken with an interrupt arriving during the lock window
    drv_br = BRC_NE; drv_ra = 0; step();
    drv_ra = 5; drv_line = 4'b0001; step();
    idle_inputs();
    cycles(5);
    // Stalled fetch fault is squashed, then taken after release
    drv_stall = 1; drv_req = 4'b0001; drv_code = 12'b000_000_000_110;
    cycles(2);
    drv_stall = 0;
    step();
    idle_inputs();
    cycles(3);
    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      drv_reset = ($urandom_range(0, 299) == 0);
      for (int s = 0; s < NS; s++) begin
        drv_req[s] = ($urandom_range(0, 9) == 0);
        drv_code[3*s +: 3] = 3'($urandom_range(0, 7));
        drv_pc[32*s +: 32] = $urandom;
      end
      drv_stall = ($urandom_range(0, 3) == 0);
      drv_sup   = ($urandom_range(0, 4) == 0);
      for (int k = 0; k < NI; k++)
        if ($urandom_range(0, 5) == 0) drv_line[k] = ~drv_line[k];
      drv_mask = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      drv_br   = 2'($urandom_range(0, 3));
      drv_ra   = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom;
      step();
    end
    drv_reset = 0;
    idle_inputs();
    cycles(2);
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
